// File: rtl/cpu_instr_feeder.sv
// Sequences a small program into the CPU: load/s pulses one cycle each, then waits for w low->high.
// Latency go->load 1 cycle; a run ends on count reached or on a per-instruction timeout.
module cpu_instr_feeder #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   num_instr,
  input  logic          go,
  input  logic          w,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int            DEPTH   = 1 << AW;
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   n, n_nxt;
  logic [AW:0]   lim;
  logic [AW-1:0] pc_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          done_nxt, err_nxt;
  logic [15:0]   cpu_in_nxt;
  logic          fetch;
  logic [AW-1:0] fetch_addr;
  logic          last;
  logic          tmo;

  assign lim  = (num_instr > DEPTH_N) ? DEPTH_N : num_instr;
  assign last = ({1'b0, pc} == (n - 1'b1));
  assign tmo  = (tcnt == TMO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= '0;
      n      <= '0;
      tcnt   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      cpu_in <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      n      <= n_nxt;
      tcnt   <= tcnt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      cpu_in <= cpu_in_nxt;
    end
  end

  // Program memory is not reset; writes are locked out for the whole run.
  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    n_nxt      = n;
    tcnt_nxt   = tcnt;
    done_nxt   = done;
    err_nxt    = err;
    fetch      = 1'b0;
    fetch_addr = pc;
    cpu_load   = (state == LOAD);
    cpu_s      = (state == START);
    busy       = (state == LOAD) || (state == START) ||
                 (state == WAIT_BUSY) || (state == WAIT_DONE);

    case (state)
      IDLE, DONE: begin
        if (go) begin
          n_nxt    = lim;
          pc_nxt   = '0;
          err_nxt  = 1'b0;
          if (lim == '0) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            done_nxt   = 1'b0;
            fetch      = 1'b1;
            fetch_addr = '0;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: state_nxt = START;
      START: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tcnt_nxt = tcnt + 1'b1;
        if (!w) begin
          state_nxt = WAIT_DONE;
        end else if (tmo) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      WAIT_DONE: begin
        tcnt_nxt = tcnt + 1'b1;
        if (w) begin
          if (last) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            pc_nxt     = pc + 1'b1;
            fetch      = 1'b1;
            fetch_addr = pc + 1'b1;
            state_nxt  = LOAD;
          end
        end else if (tmo) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // cpu_in is registered on entry to LOAD so the word is stable for the whole load cycle;
    // a same-cycle write to the fetched address is forwarded so the run sees the new word.
    cpu_in_nxt = cpu_in;
    if (fetch) begin
      if (wr_en && !busy && (wr_addr == fetch_addr))
        cpu_in_nxt = wr_data;
      else
        cpu_in_nxt = mem[fetch_addr];
    end
  end

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Bench for cpu_instr_feeder with a small behavioural CPU; loads and run end states are
// checked by a scoreboard monitor against expectations queued when each run is started.
`timescale 1ns/1ps
module tb_cpu_instr_feeder;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [AW:0]   num_instr = '0;
  logic          go = 1'b0;
  logic          w = 1'b1;
  logic [15:0]   cpu_in;
  logic          cpu_load, cpu_s, busy, done, err;
  logic [AW-1:0] pc;

  cpu_instr_feeder #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_instr(num_instr), .go(go), .w(w), .cpu_in(cpu_in), .cpu_load(cpu_load),
    .cpu_s(cpu_s), .pc(pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [15:0]  shadow [16];
  logic [15:0]  exp_q [$];
  logic [AW:0]  end_q [$];
  int           load_cnt = 0;
  int           s_cnt = 0;
  logic         prev_load = 1'b0;
  logic         done_prev = 1'b0;
  logic         busy_seen = 1'b0;

  logic [15:0]  r [8];
  logic [15:0]  ir = '0;
  int           lat = 1;
  bit           stuck = 1'b0;
  bit           pend = 1'b0;
  int           cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exec(input logic [15:0] i);
    logic [15:0] b;
    if (i[15:11] == 5'b11010) begin
      r[i[10:8]] = {{8{i[7]}}, i[7:0]};
    end else if (i[15:11] == 5'b10100) begin
      case (i[4:3])
        2'b01:   b = r[i[2:0]] << 1;
        2'b10:   b = r[i[2:0]] >> 1;
        2'b11:   b = {r[i[2:0]][15], r[i[2:0]][15:1]};
        default: b = r[i[2:0]];
      endcase
      r[i[7:5]] = r[i[10:8]] + b;
    end
  endfunction

  // CPU: drops w the cycle after s, executes after lat cycles, then raises w.
  always @(negedge clk) begin
    if (!reset) begin
      w = 1'b1; pend = 1'b0; cnt = 0;
    end else begin
      if (cpu_load) ir = cpu_in;
      if (pend) begin
        pend = 1'b0;
        if (!stuck) begin w = 1'b0; cnt = lat; end
      end else if (!w) begin
        if (cnt > 1) cnt--;
        else begin exec(ir); w = 1'b1; end
      end
      if (cpu_s) pend = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_load = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (cpu_load) begin
        load_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_load: cpu_in 0x%0h issued with no word expected", cpu_in);
        end else begin
          check("cpu_in", {16'h0, cpu_in}, {16'h0, exp_q.pop_front()});
        end
      end
      if (cpu_s || prev_load)
        check("s_follows_load", {30'h0, cpu_s, cpu_load}, {30'h0, prev_load, 1'b0});
      if (cpu_s) s_cnt++;
      prev_load = cpu_load;
      if (done && !done_prev) begin
        if (end_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_done: done rose with pc=%0d err=%0d unexpectedly", pc, err);
        end else begin
          check("end_err_pc", {27'h0, err, pc}, {27'h0, end_q.pop_front()});
        end
      end
      done_prev = done;
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic start_run(input int nn, input int nl, input int epc, input bit eerr,
                           input bit dow, input logic [AW-1:0] wa, input logic [15:0] wd);
    if (dow) shadow[wa] = wd;
    for (int i = 0; i < nl; i++) exp_q.push_back(shadow[i]);
    end_q.push_back({eerr, AW'(epc)});
    @(negedge clk);
    num_instr = (AW+1)'(nn); go = 1'b1;
    wr_en = dow; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (done !== 1'b1 && c < 5000) begin @(negedge clk); c++; end
    check(name, {31'h0, done}, 32'h1);
    repeat (2) @(negedge clk);
    check("all_words_issued", exp_q.size(), 0);
    check("end_checked", end_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_l, base_s, c;
    for (int i = 0; i < 8; i++) r[i] = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_err",  {31'h0, err}, 0);
    check("rst_load_s", {30'h0, cpu_load, cpu_s}, 0);
    check("rst_pc",   {28'h0, pc}, 0);
    check("rst_cpu_in", {16'h0, cpu_in}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Zero-length run
    busy_seen = 1'b0;
    end_q.push_back({1'b0, 4'd0});
    num_instr = '0; go = 1'b1;
    @(posedge clk); #1;
    check("zero_done_next_cycle", {31'h0, done}, 1);
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_no_busy", {31'h0, busy_seen}, 0);
    check("zero_no_pulses", load_cnt + s_cnt, 0);

    // Three-instruction program with exact go->load->s timing
    shadow[0] = 16'hD007; shadow[1] = 16'hD102; shadow[2] = 16'hA148;
    for (int i = 0; i < 3; i++) wr(AW'(i), shadow[i]);
    lat = 3;
    base_l = load_cnt; base_s = s_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(shadow[i]);
    end_q.push_back({1'b0, 4'd2});
    @(negedge clk); num_instr = 5'd3; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    check("k1_load", {30'h0, cpu_load, cpu_s}, 2);
    @(posedge clk); #1;
    check("k2_s", {30'h0, cpu_load, cpu_s}, 1);
    wait_done("prog3_done");
    check("prog3_err_pc", {27'h0, err, pc}, 5'h02);
    check("prog3_r0", {16'h0, r[0]}, 16'h0007);
    check("prog3_r1", {16'h0, r[1]}, 16'h0002);
    check("prog3_r2", {16'h0, r[2]}, 16'h0010);
    check("prog3_loads", load_cnt - base_l, 3);
    check("prog3_s", s_cnt - base_s, 3);

    // CPU ignores s: timeout exactly TIMEOUT cycles after WAIT_BUSY entry
    stuck = 1'b1;
    exp_q.push_back(shadow[0]);
    end_q.push_back({1'b1, 4'd0});
    @(negedge clk); num_instr = 5'd2; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    repeat (TIMEOUT + 1) @(posedge clk);
    #1;
    check("tmo_not_early", {31'h0, done}, 0);
    @(posedge clk); #1;
    check("tmo_done_err", {30'h0, done, err}, 3);
    check("tmo_pc", {28'h0, pc}, 0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_end_checked", end_q.size(), 0);

    // Async reset while waiting for the CPU
    lat = 12;
    start_run(3, 3, 2, 0, 1'b0, '0, '0);
    c = 0;
    while (w !== 1'b0 && c < 200) begin @(negedge clk); c++; end
    check("mid_w_low", {31'h0, w}, 0);
    @(negedge clk);
    check("mid_busy", {31'h0, busy}, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_flags", {27'h0, busy, done, err, cpu_load, cpu_s}, 0);
    check("mid_rst_pc", {28'h0, pc}, 0);
    exp_q.delete(); end_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lat = 1;
    start_run(3, 3, 2, 0, 1'b0, '0, '0);
    wait_done("rerun_done");

    // Write while busy is dropped; writes in DONE (including same cycle as go) land
    lat = 4;
    start_run(3, 3, 2, 0, 1'b0, '0, '0);
    check("wr_busy_pre", {31'h0, busy}, 1);
    wr(1, 16'hBEEF);
    check("wr_busy_post", {31'h0, busy}, 1);
    wait_done("wr_busy_done");
    shadow[1] = 16'h1234;
    wr(1, 16'h1234);
    start_run(3, 3, 2, 0, 1'b1, '0, 16'h5678);
    wait_done("wr_done_run");

    // Oversized count is clamped to the memory depth
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 16'h1000 + 16'(i);
      wr(AW'(i), shadow[i]);
    end
    base_l = load_cnt;
    start_run(17, 16, 15, 0, 1'b0, '0, '0);
    wait_done("over_done");
    check("over_loads", load_cnt - base_l, 16);
    check("over_pc", {28'h0, pc}, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
